// File: rtl/addsub_operand_seq_pkg.sv
// Shared encodings and defaults for the addsub4b operand sequencer.
// Holds the FSM state encoding, the operation codes and the signed-overflow rule.
package addsub_operand_seq_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 4;
    localparam int DEF_DB_W        = 16;

    // Subtraction adds ~B, so the effective B sign is inverted before comparing.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic op,    input logic r_msb);
        return (a_msb == (b_msb ^ (op == OP_SUB))) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_operand_seq_btn_pulse.sv
// Button conditioner: synchroniser, counting debouncer and rising-edge pulse.
// The pulse is registered and appears SYNC_STAGES + DB_CYCLES edges after raw rises.
module btn_pulse
    import addsub_operand_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int DB_W        = DEF_DB_W
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic pulse
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[SYNC_STAGES-1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + DB_W'(1);
            end
        end
        pulse_d = level_d & ~level_q;
    end

    // NOTE: state is updated only with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/addsub_operand_seq.sv
// Operand sequencer and result latch for the external combinational addsub4b.
// Loads A, then B and the operation, lets the adder settle one cycle, then shows the result.
module addsub_operand_seq
    import addsub_operand_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int DB_W        = DEF_DB_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] sw,
    input  logic       op_sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       add_sub,
    input  logic [3:0] R,
    input  logic       Co,
    output logic [3:0] result,
    output logic       carry,
    output logic       ovf,
    output logic       valid,
    output logic [1:0] state
);

    logic enter_pulse, clear_pulse;

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_btn_enter (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_enter),
        .pulse   (enter_pulse)
    );

    btn_pulse #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_btn_clear (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_clear),
        .pulse   (clear_pulse)
    );

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic       add_sub_q, add_sub_d, carry_q, carry_d;
    logic       ovf_q, ovf_d, valid_q, valid_d;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        add_sub_d = add_sub_q;
        result_d  = result_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        valid_d   = valid_q;

        unique case (state_q)
            S_A: if (enter_pulse) begin
                a_d     = sw;
                state_d = S_B;
            end
            S_B: if (enter_pulse) begin
                b_d       = sw;
                add_sub_d = op_sw;
                state_d   = S_EXEC;
            end
            // A/B/add_sub have been stable since the previous edge, so R/Co are settled here.
            S_EXEC: begin
                result_d = R;
                carry_d  = Co;
                ovf_d    = signed_ovf(a_q[3], b_q[3], add_sub_q, R[3]);
                valid_d  = 1'b1;
                state_d  = S_SHOW;
            end
            S_SHOW: if (enter_pulse) begin
                valid_d = 1'b0;
                state_d = S_A;
            end
            default: state_d = S_A;
        endcase

        // Clear overrides everything, including a coincident enter.
        if (clear_pulse) begin
            state_d   = S_A;
            a_d       = '0;
            b_d       = '0;
            add_sub_d = 1'b0;
            result_d  = '0;
            carry_d   = 1'b0;
            ovf_d     = 1'b0;
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            add_sub_q <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            add_sub_q <= add_sub_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign add_sub = add_sub_q;
    assign result  = result_q;
    assign carry   = carry_q;
    assign ovf     = ovf_q;
    assign valid   = valid_q;
    assign state   = state_q;

endmodule

// File: tb/tb_addsub_operand_seq.sv
// Directed bench for addsub_operand_seq with a behavioural addsub4b on R/Co.
// Buttons are driven 1 ns after a rising edge; outputs are sampled 1 ns after an edge.
module tb_addsub_operand_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] sw = '0;
    logic       op_sw = 1'b0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] A, B, R, result;
    logic       add_sub, Co, carry, ovf, valid;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    addsub_operand_seq #(.SYNC_STAGES(2), .DB_CYCLES(4), .DB_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw        (sw),
        .op_sw     (op_sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .A         (A),
        .B         (B),
        .add_sub   (add_sub),
        .R         (R),
        .Co        (Co),
        .result    (result),
        .carry     (carry),
        .ovf       (ovf),
        .valid     (valid),
        .state     (state)
    );

    // Behavioural 4-bit adder/subtractor standing in for the board's addsub4b.
    logic [4:0] sum;
    always_comb begin
        sum = add_sub ? ({1'b0, A} + {1'b0, ~B} + 5'd1) : ({1'b0, A} + {1'b0, B});
        R   = sum[3:0];
        Co  = sum[4];
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input logic [3:0] v);
        sw = v;
        btn_enter = 1'b1;
        edges(12);
        btn_enter = 1'b0;
        edges(12);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        edges(12);
        btn_clear = 1'b0;
        edges(12);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        edges(3);
        checks++;
        if ({A, B, add_sub, result, carry, ovf, valid, state} !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs: got A=%b B=%b op=%b r=%b c=%b o=%b v=%b st=%0d, want all 0",
                     A, B, add_sub, result, carry, ovf, valid, state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        edges(2);
    endtask

    task automatic test_debounce();
        int pulses = 0;
        int first_edge = 0;
        sw = 4'b0000;
        btn_enter = 1'b1;
        edges(3);
        btn_enter = 1'b0;
        edges(15);
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL glitch_no_pulse: state=%0d want 0", state);
        end
        btn_enter = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            edges(1);
            if (dut.u_btn_enter.pulse === 1'b1) begin
                pulses++;
                if (first_edge == 0) first_edge = e;
            end
        end
        checks++;
        if (pulses != 1 || first_edge != 6) begin
            failures++;
            $display("FAIL hold_pulse: pulses=%0d at edge %0d, want 1 at edge 6", pulses, first_edge);
        end
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL hold_state: state=%0d want 1", state);
        end
        btn_enter = 1'b0;
        edges(15);
        checks++;
        if (state !== 2'd1) begin
            failures++;
            $display("FAIL release_no_pulse: state=%0d want 1", state);
        end
        press_clear();
        checks++;
        if (state !== 2'd0 || A !== 4'd0) begin
            failures++;
            $display("FAIL clear_from_b: state=%0d A=%b want 0 0000", state, A);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic op, input logic [3:0] er, input logic ec, input logic eo);
        press_enter(a);
        checks++;
        if (state !== 2'd1 || A !== a) begin
            failures++;
            $display("FAIL %s_load_a: state=%0d A=%b want 1 %b", name, state, A, a);
        end
        sw = b;
        op_sw = op;
        btn_enter = 1'b1;
        edges(7);
        checks++;
        if (state !== 2'd2 || valid !== 1'b0 || B !== b || add_sub !== op) begin
            failures++;
            $display("FAIL %s_exec: state=%0d valid=%b B=%b op=%b want 2 0 %b %b",
                     name, state, valid, B, add_sub, b, op);
        end
        edges(1);
        checks++;
        if (state !== 2'd3 || valid !== 1'b1 || result !== er || carry !== ec || ovf !== eo) begin
            failures++;
            $display("FAIL %s_show: state=%0d valid=%b result=%b carry=%b ovf=%b want 3 1 %b %b %b",
                     name, state, valid, result, carry, ovf, er, ec, eo);
        end
        btn_enter = 1'b0;
        edges(12);
    endtask

    task automatic leave_show(input string name, input logic [3:0] er);
        press_enter(4'b0000);
        checks++;
        if (state !== 2'd0 || valid !== 1'b0 || result !== er) begin
            failures++;
            $display("FAIL %s_leave: state=%0d valid=%b result=%b want 0 0 %b", name, state, valid, result, er);
        end
    endtask

    task automatic test_add();
        run_op("add", 4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0);
        leave_show("add", 4'b0001);
    endtask

    task automatic test_sub();
        run_op("sub", 4'b1110, 4'b1100, 1'b1, 4'b0010, 1'b1, 1'b0);
        leave_show("sub", 4'b0010);
    endtask

    task automatic test_overflow();
        run_op("ovf_pos", 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        leave_show("ovf_pos", 4'b1000);
        run_op("ovf_none", 4'b1010, 4'b0011, 1'b0, 4'b1101, 1'b0, 1'b0);
        leave_show("ovf_none", 4'b1101);
    endtask

    task automatic test_zero();
        run_op("zero", 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0);
        leave_show("zero", 4'b0000);
    endtask

    task automatic test_clear_enter();
        press_enter(4'b0101);
        checks++;
        if (state !== 2'd1 || A !== 4'b0101) begin
            failures++;
            $display("FAIL clr_setup: state=%0d A=%b want 1 0101", state, A);
        end
        sw = 4'b1001;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        edges(12);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        edges(12);
        checks++;
        if (state !== 2'd0 || A !== 4'd0 || B !== 4'd0) begin
            failures++;
            $display("FAIL clr_wins: state=%0d A=%b B=%b want 0 0000 0000", state, A, B);
        end
    endtask

    task automatic test_reset_mid();
        run_op("pre_rst", 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({A, B, add_sub, result, carry, ovf, valid, state} !== 17'd0) begin
            failures++;
            $display("FAIL async_reset: A=%b B=%b op=%b r=%b c=%b o=%b v=%b st=%0d want all 0",
                     A, B, add_sub, result, carry, ovf, valid, state);
        end
        btn_enter = 1'b1;
        sw = 4'b0110;
        edges(3);
        @(negedge clk);
        reset_n = 1'b1;
        edges(6);
        checks++;
        if (state !== 2'd0) begin
            failures++;
            $display("FAIL held_early: state=%0d want 0", state);
        end
        edges(1);
        checks++;
        if (state !== 2'd1 || A !== 4'b0110) begin
            failures++;
            $display("FAIL held_pulse: state=%0d A=%b want 1 0110", state, A);
        end
        btn_enter = 1'b0;
        edges(12);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_add();
        test_sub();
        test_overflow();
        test_zero();
        test_clear_enter();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
